// File: rtl/b2a_pkg.sv
// rtl/b2a_pkg.sv - shared constants and helpers for the Boolean-unmask / B2A pipeline
// Randomness-set sizing and share-slice indexing, reused across the XOR and B2A stages.
package b2a_pkg;

  function automatic int log_k(input int n);
    return $clog2(n + 1) - 1;
  endfunction

  // Random words consumed by one refresh of an n-share XOR tree.
  function automatic int randnum(input int n);
    int lk;
    lk = log_k(n);
    return lk * (2 ** (lk - 1)) + n - (2 ** lk);
  endfunction

  function automatic int share_lo(input int j, input int k_width);
    return j * k_width;
  endfunction

endpackage

// File: rtl/rnd_pingpong_buf.sv
// rtl/rnd_pingpong_buf.sv - fill/active randomness ping-pong buffer with word counter
// Collects RANDNUM words in arrival order; a swap moves the fill set to active and restarts filling.
module rnd_pingpong_buf
  import b2a_pkg::*;
#(
  parameter int K_WIDTH = 32,
  parameter int RANDNUM = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ena,
  input  logic                       i_rvld,
  input  logic [K_WIDTH-1:0]         i_rnd,
  output logic                       o_rrdy,
  input  logic                       i_swap,
  output logic                       o_full,
  output logic [K_WIDTH*RANDNUM-1:0] o_active
);

  localparam int CW = $clog2(RANDNUM + 1);

  logic [CW-1:0]              cnt_q, cnt_d;
  logic [K_WIDTH*RANDNUM-1:0] fill_q, fill_d;
  logic [K_WIDTH*RANDNUM-1:0] active_q, active_d;
  logic                       wr;

  assign o_rrdy   = ena & (cnt_q < CW'(RANDNUM));
  assign o_full   = (cnt_q == CW'(RANDNUM));
  assign o_active = active_q;
  assign wr       = i_rvld & o_rrdy;

  // Swap only happens when full, so it never coincides with a write.
  always_comb begin
    cnt_d    = cnt_q;
    fill_d   = fill_q;
    active_d = active_q;
    if (i_swap) begin
      active_d = fill_q;
      cnt_d    = '0;
    end else if (wr) begin
      fill_d[share_lo(int'(cnt_q), K_WIDTH) +: K_WIDTH] = i_rnd;
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      fill_q   <= '0;
      active_q <= '0;
    end else if (ena) begin
      cnt_q    <= cnt_d;
      fill_q   <= fill_d;
      active_q <= active_d;
    end
  end

endmodule

// File: rtl/rnd_share_sync_n4.sv
// rtl/rnd_share_sync_n4.sv - releases share bundles only alongside a fresh randomness set
// Optional RNDSYNC_STALL_CNT_EN adds a saturating randomness-starvation counter (o_stall_cnt).
module rnd_share_sync_n4
  import b2a_pkg::*;
#(
  parameter int K_WIDTH   = 32,
  parameter int N_SHARES  = 4,
  parameter int MASKWIDTH = K_WIDTH * N_SHARES,
  parameter int RANDNUM   = randnum(N_SHARES)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ena,
  input  logic                       i_rvld,
  input  logic [K_WIDTH-1:0]         i_rnd,
  output logic                       o_rrdy,
  input  logic                       i_dvld,
  input  logic [MASKWIDTH-1:0]       i_x,
  output logic                       o_xrdy,
  output logic [MASKWIDTH-1:0]       o_x,
  output logic [K_WIDTH*RANDNUM-1:0] o_rnd,
`ifdef RNDSYNC_STALL_CNT_EN
  output logic [15:0]                o_stall_cnt,
`endif
  output logic                       o_dvld
);

  logic                 full;
  logic                 accept;
  logic [MASKWIDTH-1:0] x_q, x_d;
  logic                 dvld_q, dvld_d;

  assign o_xrdy = ena & full;
  assign accept = i_dvld & o_xrdy;

  rnd_pingpong_buf #(
    .K_WIDTH (K_WIDTH),
    .RANDNUM (RANDNUM)
  ) u_buf (
    .clk      (clk),
    .rst      (rst),
    .ena      (ena),
    .i_rvld   (i_rvld),
    .i_rnd    (i_rnd),
    .o_rrdy   (o_rrdy),
    .i_swap   (accept),
    .o_full   (full),
    .o_active (o_rnd)
  );

  always_comb begin
    x_d    = x_q;
    dvld_d = accept;
    if (accept) x_d = i_x;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q    <= '0;
      dvld_q <= 1'b0;
    end else if (ena) begin
      x_q    <= x_d;
      dvld_q <= dvld_d;
    end
  end

  assign o_x    = x_q;
  assign o_dvld = dvld_q;

`ifdef RNDSYNC_STALL_CNT_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (ena && i_dvld && !o_xrdy && stall_q != 16'hFFFF) stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_q <= '0;
    else     stall_q <= stall_d;
  end

  assign o_stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_rnd_share_sync_n4.sv
// tb/tb_rnd_share_sync_n4.sv - directed self-checking bench for rnd_share_sync_n4
// Checks reset, fill/accept, hold, spacing, ena freeze and async reset (stall counter under RNDSYNC_STALL_CNT_EN).
module tb_rnd_share_sync_n4;

  logic         clk = 1'b0;
  logic         rst;
  logic         ena;
  logic         i_rvld;
  logic [31:0]  i_rnd;
  logic         o_rrdy;
  logic         i_dvld;
  logic [127:0] i_x;
  logic         o_xrdy;
  logic [127:0] o_x;
  logic [127:0] o_rnd;
  logic         o_dvld;
`ifdef RNDSYNC_STALL_CNT_EN
  logic [15:0]  o_stall_cnt;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  rnd_share_sync_n4 dut (
    .clk    (clk),
    .rst    (rst),
    .ena    (ena),
    .i_rvld (i_rvld),
    .i_rnd  (i_rnd),
    .o_rrdy (o_rrdy),
    .i_dvld (i_dvld),
    .i_x    (i_x),
    .o_xrdy (o_xrdy),
    .o_x    (o_x),
    .o_rnd  (o_rnd),
`ifdef RNDSYNC_STALL_CNT_EN
    .o_stall_cnt (o_stall_cnt),
`endif
    .o_dvld (o_dvld)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; ena = 1'b1; i_rvld = 1'b0; i_rnd = '0; i_dvld = 1'b0; i_x = '0;
    #3;
    rst = 1'b0;
    step();
  endtask

  task automatic feed(input logic [31:0] w);
    i_rvld = 1'b1;
    i_rnd  = w;
    step();
    i_rvld = 1'b0;
  endtask

  logic [31:0] a [4];
  logic [31:0] x32;
  int          last_pulse, pulse_n, cyc, word;
  logic [127:0] exp_set;

  initial begin
    do_reset();
    // 1: reset state, starvation, first bundle
    chk("rst_o_dvld", {127'd0, o_dvld}, 128'd0);
    chk("rst_o_x", o_x, 128'd0);
    chk("rst_o_rnd", o_rnd, 128'd0);
    chk("rst_o_rrdy", {127'd0, o_rrdy}, 128'd1);
    chk("rst_o_xrdy", {127'd0, o_xrdy}, 128'd0);
    i_dvld = 1'b1;
    i_x    = 128'hAAAA_0003_AAAA_0002_AAAA_0001_AAAA_0000;
    for (int i = 0; i < 10; i++) step();
    chk("starve_xrdy", {127'd0, o_xrdy}, 128'd0);
    chk("starve_dvld", {127'd0, o_dvld}, 128'd0);
`ifdef RNDSYNC_STALL_CNT_EN
    chk("stall_cnt10", {112'd0, o_stall_cnt}, 128'd10);
`endif
    a[0] = 32'hA0A0_0000; a[1] = 32'hA1A1_1111; a[2] = 32'hA2A2_2222; a[3] = 32'hA3A3_3333;
    for (int i = 0; i < 4; i++) feed(a[i]);
    chk("full_xrdy", {127'd0, o_xrdy}, 128'd1);
    chk("full_rrdy", {127'd0, o_rrdy}, 128'd0);
    step();
    i_dvld = 1'b0;
    chk("t1_dvld", {127'd0, o_dvld}, 128'd1);
    chk("t1_o_x", o_x, 128'hAAAA_0003_AAAA_0002_AAAA_0001_AAAA_0000);
    chk("t1_o_rnd", o_rnd, {a[3], a[2], a[1], a[0]});
    step();
    chk("t1_dvld_drop", {127'd0, o_dvld}, 128'd0);

    // 2: share 4_3_2_1, hold and downstream XOR
    for (int i = 1; i <= 4; i++) feed(32'(i));
    i_dvld = 1'b1;
    i_x    = {32'h4, 32'h3, 32'h2, 32'h1};
    step();
    i_dvld = 1'b0;
    chk("t2_o_x", o_x, {32'h4, 32'h3, 32'h2, 32'h1});
    chk("t2_rnd_c0", o_rnd, {32'h4, 32'h3, 32'h2, 32'h1});
    x32 = o_x[31:0] ^ o_x[63:32] ^ o_x[95:64] ^ o_x[127:96];
    chk("t2_xor", {96'd0, x32}, 128'd4);
    step();
    chk("t2_rnd_c1", o_rnd, {32'h4, 32'h3, 32'h2, 32'h1});

    // 3: back-to-back, rvld and dvld always high
    word = 100; pulse_n = 0; last_pulse = 0;
    i_dvld = 1'b1; i_rvld = 1'b1; i_rnd = 32'(word);
    for (cyc = 1; cyc <= 30 && pulse_n < 3; cyc++) begin
      i_x = {96'd0, 32'(cyc)};
      i_rnd = 32'(word);
      if (o_rrdy) word++;
      step();
      if (o_dvld) begin
        exp_set = {32'(100 + 4*pulse_n + 3), 32'(100 + 4*pulse_n + 2),
                   32'(100 + 4*pulse_n + 1), 32'(100 + 4*pulse_n)};
        chk($sformatf("t3_set%0d", pulse_n), o_rnd, exp_set);
        if (pulse_n > 0) chk($sformatf("t3_gap%0d", pulse_n), 128'(cyc - last_pulse), 128'd5);
        last_pulse = cyc;
        pulse_n++;
      end
    end
    chk("t3_pulses", 128'(pulse_n), 128'd3);

    // 4: ena freeze mid-fill and during o_dvld
    do_reset();
    a[0] = 32'hB000_0000; a[1] = 32'hB111_1111; a[2] = 32'hB222_2222; a[3] = 32'hB333_3333;
    feed(a[0]); feed(a[1]);
    ena = 1'b0; i_rvld = 1'b1; i_rnd = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) step();
    chk("t4_rrdy_off", {127'd0, o_rrdy}, 128'd0);
    ena = 1'b1; i_rvld = 1'b0;
    feed(a[2]); feed(a[3]);
    i_dvld = 1'b1; i_x = {4{32'hC0FF_EE00}};
    step();
    i_dvld = 1'b0; ena = 1'b0;
    for (int i = 0; i < 3; i++) step();
    chk("t4_dvld_held", {127'd0, o_dvld}, 128'd1);
    chk("t4_order", o_rnd, {a[3], a[2], a[1], a[0]});
    chk("t4_xrdy_off", {127'd0, o_xrdy}, 128'd0);
    ena = 1'b1;
    step();
    chk("t4_dvld_drop", {127'd0, o_dvld}, 128'd0);

    // 5: async reset with o_dvld high, then mid-fill at cnt=3
    for (int i = 0; i < 4; i++) feed(32'h5000 + 32'(i));
    i_dvld = 1'b1; i_x = {4{32'h5555_5555}};
    step();
    i_dvld = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("t5_async_dvld", {127'd0, o_dvld}, 128'd0);
    chk("t5_async_x", o_x, 128'd0);
    chk("t5_async_rnd", o_rnd, 128'd0);
    rst = 1'b0;
    step();
    for (int i = 0; i < 3; i++) feed(32'h6000 + 32'(i));
    #2 rst = 1'b1;
    #1 rst = 1'b0;
    step();
    i_dvld = 1'b1;
    for (int i = 0; i < 3; i++) feed(32'h7000 + 32'(i));
    chk("t5_need4_xrdy", {127'd0, o_xrdy}, 128'd0);
    feed(32'h7003);
    chk("t5_full_xrdy", {127'd0, o_xrdy}, 128'd1);
    step();
    i_dvld = 1'b0;
    chk("t5_fresh_set", o_rnd, {32'h7003, 32'h7002, 32'h7001, 32'h7000});

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
